// File: rtl/program_loader.sv
// Program loader: receives a host byte stream, packs it MSB-first into
// 32-bit words and writes them into instruction memory while holding the
// processor in reset. All outputs are decoded from registered state only.
module program_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  len,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [5:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_reg;
    logic [5:0]  len_q;
    logic        byte_take;
    logic        last_word;

    // A byte is only taken in RECV, where byte_ready is high.
    assign byte_take = (state == RECV) && byte_valid;

    // len of 0 stands for 64 words, so the final index is len-1 modulo 64.
    assign last_word = (word_idx == (len_q - 6'd1));

    // Main sequencer: load setup, byte assembly, word stepping and abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            word_idx <= 6'd0;
            byte_cnt <= 2'd0;
            asm_reg  <= 32'd0;
            len_q    <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RECV;
                        len_q    <= len;
                        word_idx <= 6'd0;
                        byte_cnt <= 2'd0;
                        asm_reg  <= 32'd0;
                    end
                end
                RECV: begin
                    if (abort) begin
                        state    <= IDLE;
                        byte_cnt <= 2'd0;
                        asm_reg  <= 32'd0;
                    end else if (byte_take) begin
                        asm_reg  <= {asm_reg[23:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (last_word) begin
                        state <= DONE;
                    end else begin
                        word_idx <= word_idx + 6'd1;
                        state    <= RECV;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode; memory bus is zero outside the write cycle.
    always_comb begin
        byte_ready = (state == RECV);
        mem_we     = (state == WRITE);
        mem_addr   = (state == WRITE) ? {word_idx, 2'b00} : 8'd0;
        mem_data   = (state == WRITE) ? asm_reg : 32'd0;
        cpu_reset  = (state != IDLE);
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

endmodule
